// File: rtl/led_pwm_pkg.sv
// Shared constants for the status-LED driver: channel modes, special register
// addresses and the CTRL reset value.
package led_pwm_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'b00,
    MODE_ON       = 2'b01,
    MODE_BLINK    = 2'b10,
    MODE_ACTIVITY = 2'b11
  } mode_e;

  localparam logic [3:0] ADDR_STATUS = 4'hE;
  localparam logic [3:0] ADDR_GLOBAL = 4'hF;
  localparam logic [7:0] CTRL_RESET  = 8'hC8;

endpackage

// File: rtl/led_pwm_ctl_if.sv
// Support-CPU IO bus slot seen by the LED driver: write/read strobes, address,
// write data and registered read data.
interface led_pwm_ctl_if;
  logic       wr_i;
  logic       rd_i;
  logic [3:0] A_i;
  logic [7:0] D_i;
  logic [7:0] D_o;

  modport master (output wr_i, rd_i, A_i, D_i, input D_o);
  modport slave  (input wr_i, rd_i, A_i, D_i, output D_o);
endinterface

// File: rtl/led_channel.sv
// One LED channel: CTRL register, activity stretch counter and mode mux that
// produces the registered LED drive from the shared PWM/blink timebase.
module led_channel
  import led_pwm_pkg::*;
#(
  parameter int PWM_BITS     = 4,
  parameter int STRETCH_BITS = 21
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                i_we,
  input  logic [1:0]          i_wmode,
  input  logic [PWM_BITS-1:0] i_wduty,
  input  logic                i_activity,
  input  logic                i_level,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  input  logic                i_blink_ph,
  output logic [7:0]          o_ctrl,
  output logic                o_led
);

  mode_e                   r_mode;
  logic [PWM_BITS-1:0]     r_duty;
  logic [STRETCH_BITS-1:0] r_stretch;
  logic                    r_led;

  logic w_pwm_on;
  logic w_stretch;
  logic w_led_nxt;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_mode <= mode_e'(CTRL_RESET[7:6]);
      r_duty <= PWM_BITS'(CTRL_RESET[5:0]);
    end else if (i_we) begin
      r_mode <= mode_e'(i_wmode);
      r_duty <= i_wduty;
    end
  end

  // A new activity strobe always restarts the full stretch, even mid-count.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      r_stretch <= '0;
    else if (i_activity)
      r_stretch <= '1;
    else if (r_stretch != '0)
      r_stretch <= r_stretch - 1'b1;
  end

  always_comb begin
    w_pwm_on  = (i_pwm_cnt < r_duty);
    w_stretch = (r_stretch != '0);
    w_led_nxt = 1'b0;
    case (r_mode)
      MODE_OFF:      w_led_nxt = 1'b0;
      MODE_ON:       w_led_nxt = w_pwm_on;
      MODE_BLINK:    w_led_nxt = i_blink_ph & w_pwm_on;
      MODE_ACTIVITY: w_led_nxt = w_stretch | (i_level & w_pwm_on);
      default:       w_led_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      r_led <= 1'b0;
    else
      r_led <= w_led_nxt;
  end

  assign o_ctrl = {r_mode, 6'(r_duty)};
  assign o_led  = r_led;

endmodule

// File: rtl/led_pwm_ctl.sv
// Multi-channel status-LED driver: shared PWM/blink counters, GLOBAL register,
// register decode and registered read-back on the IO bus.
module led_pwm_ctl
  import led_pwm_pkg::*;
#(
  parameter int NUM_LEDS     = 4,
  parameter int PWM_BITS     = 4,
  parameter int STRETCH_BITS = 21,
  parameter int BLINK_BITS   = 24
) (
  input  logic                clk_i,
  input  logic                reset_i,
  led_pwm_ctl_if.slave        bus,
  input  logic [NUM_LEDS-1:0] activity_i,
  input  logic [NUM_LEDS-1:0] level_i,
  output logic [NUM_LEDS-1:0] led_o
);

  logic [PWM_BITS-1:0]   r_pwm_cnt;
  logic [BLINK_BITS-1:0] r_blink_cnt;
  logic [1:0]            r_global;
  logic [7:0]            r_dout;

  logic                w_blink_ph;
  logic [NUM_LEDS-1:0] w_ctrl_we;
  logic [7:0]          w_ctrl_rd [NUM_LEDS];
  logic [7:0]          w_rdata;
  logic                w_unused_wdata;

  // Bits of D_i not stored by any register are intentionally discarded.
  assign w_unused_wdata = ^bus.D_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pwm_cnt   <= '0;
      r_blink_cnt <= '0;
    end else begin
      r_pwm_cnt   <= r_pwm_cnt + 1'b1;
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      r_global <= 2'd0;
    else if (bus.wr_i && (bus.A_i == ADDR_GLOBAL))
      r_global <= bus.D_i[1:0];
  end

  // Larger rate picks a lower prescaler bit, i.e. a faster blink.
  always_comb begin
    w_blink_ph = 1'b0;
    case (r_global)
      2'd0: w_blink_ph = r_blink_cnt[BLINK_BITS-1];
      2'd1: w_blink_ph = r_blink_cnt[BLINK_BITS-2];
      2'd2: w_blink_ph = r_blink_cnt[BLINK_BITS-3];
      2'd3: w_blink_ph = r_blink_cnt[BLINK_BITS-4];
      default: w_blink_ph = 1'b0;
    endcase
  end

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
    assign w_ctrl_we[g] = bus.wr_i && (bus.A_i == 4'(g));

    led_channel #(
      .PWM_BITS     (PWM_BITS),
      .STRETCH_BITS (STRETCH_BITS)
    ) u_ch (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .i_we       (w_ctrl_we[g]),
      .i_wmode    (bus.D_i[7:6]),
      .i_wduty    (bus.D_i[PWM_BITS-1:0]),
      .i_activity (activity_i[g]),
      .i_level    (level_i[g]),
      .i_pwm_cnt  (r_pwm_cnt),
      .i_blink_ph (w_blink_ph),
      .o_ctrl     (w_ctrl_rd[g]),
      .o_led      (led_o[g])
    );
  end

  always_comb begin
    w_rdata = 8'h00;
    if (bus.A_i == ADDR_STATUS)
      w_rdata = 8'(led_o);
    else if (bus.A_i == ADDR_GLOBAL)
      w_rdata = {6'd0, r_global};
    else
      for (int i = 0; i < NUM_LEDS; i++)
        if (bus.A_i == 4'(i)) w_rdata = w_ctrl_rd[i];
  end

  // Read mux sees pre-edge register state, so a same-edge write reads old data.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      r_dout <= 8'h00;
    else if (bus.rd_i)
      r_dout <= w_rdata;
  end

  assign bus.D_o = r_dout;

endmodule

// File: tb/tb_led_pwm_ctl.sv
// Bench for led_pwm_ctl: directed scenarios plus random traffic against a
// time-based reference model of the LED and read-back behaviour.
module tb_led_pwm_ctl;

  localparam int NL = 4;
  localparam int PB = 4;
  localparam int SB = 4;
  localparam int BB = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NL-1:0] act = '0;
  logic [NL-1:0] lvl = '0;
  logic [NL-1:0] led;

  led_pwm_ctl_if u_if ();

  led_pwm_ctl #(
    .NUM_LEDS     (NL),
    .PWM_BITS     (PB),
    .STRETCH_BITS (SB),
    .BLINK_BITS   (BB)
  ) dut (
    .clk_i      (clk),
    .reset_i    (rst),
    .bus        (u_if),
    .activity_i (act),
    .level_i    (lvl),
    .led_o      (led)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: time since reset and time of last activity per channel.
  int          m_mode [NL];
  int          m_duty [NL];
  longint      m_last [NL];
  int          m_global;
  longint      m_cyc;
  logic [NL-1:0] m_led;
  logic [7:0]  m_dout;

  function automatic logic [7:0] m_read(input logic [3:0] a);
    if (int'(a) < NL) return 8'((m_mode[int'(a)] << 6) | m_duty[int'(a)]);
    if (a == 4'hE) return 8'(m_led);
    if (a == 4'hF) return 8'(m_global);
    return 8'h00;
  endfunction

  task automatic tick();
    logic [NL-1:0] nled;
    int pwm, bph;
    bit on, st;
    longint d;
    if (rst) begin
      for (int c = 0; c < NL; c++) begin
        m_mode[c] = 3; m_duty[c] = 8; m_last[c] = -1000;
      end
      m_global = 0; m_cyc = 0; m_led = '0; m_dout = 8'h00;
    end else begin
      pwm = int'(m_cyc % 16);
      bph = int'(((m_cyc % 64) >> (5 - m_global)) & 1);
      for (int c = 0; c < NL; c++) begin
        on = (pwm < m_duty[c]);
        d  = m_cyc - m_last[c];
        st = (d >= 1) && (d <= 15);
        case (m_mode[c])
          0: nled[c] = 1'b0;
          1: nled[c] = on;
          2: nled[c] = (bph == 1) && on;
          default: nled[c] = st || (lvl[c] && on);
        endcase
      end
      if (u_if.rd_i) m_dout = m_read(u_if.A_i);
      if (u_if.wr_i) begin
        if (int'(u_if.A_i) < NL) begin
          m_mode[int'(u_if.A_i)] = int'(u_if.D_i) >> 6;
          m_duty[int'(u_if.A_i)] = int'(u_if.D_i) & 15;
        end else if (u_if.A_i == 4'hF) begin
          m_global = int'(u_if.D_i) & 3;
        end
      end
      for (int c = 0; c < NL; c++) if (act[c]) m_last[c] = m_cyc;
      m_cyc++;
      m_led = nled;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
    u_if.wr_i = 1'b1; u_if.A_i = a; u_if.D_i = d;
    tick();
    u_if.wr_i = 1'b0;
  endtask

  task automatic rd_reg(input logic [3:0] a);
    u_if.rd_i = 1'b1; u_if.A_i = a;
    tick();
    u_if.rd_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] addrs [6];
    logic [7:0] exps  [6];
    addrs = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hF, 4'hE};
    exps  = '{8'hC8, 8'hC8, 8'hC8, 8'hC8, 8'h00, 8'h00};
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if (led !== 4'b0000 || u_if.D_o !== 8'h00) begin
      n_err++; $display("FAIL reset_state led=%b dout=%h want led=0000 dout=00", led, u_if.D_o);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rd_reg(addrs[i]);
      n_vec++;
      if (u_if.D_o !== exps[i] || led !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_read a=%h got=%h led=%b want=%h led=0000", addrs[i], u_if.D_o, led, exps[i]);
      end
    end
  endtask

  task automatic test_pwm_on();
    int cnt = 0;
    wr_reg(4'h1, 8'h43);
    for (int i = 0; i < 32; i++) begin
      tick();
      if (i >= 16 && led[1]) cnt++;
      n_vec++;
      if (led !== m_led) begin
        n_err++; $display("FAIL pwm_on cyc=%0d led=%b want=%b", i, led, m_led);
      end
    end
    n_vec++;
    if (cnt != 3) begin
      n_err++; $display("FAIL pwm_on_count got=%0d want=3", cnt);
    end
  endtask

  task automatic test_activity();
    act[0] = 1'b1;
    tick();
    act[0] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_vec++;
      if (led[0] !== (i <= 15)) begin
        n_err++; $display("FAIL stretch_single i=%0d led0=%b want=%b", i, led[0], (i <= 15));
      end
    end
    for (int i = 0; i <= 40; i++) begin
      act[0] = (i == 0 || i == 10);
      tick();
      act[0] = 1'b0;
      n_vec++;
      if (led[0] !== (i >= 1 && i <= 25) || led !== m_led) begin
        n_err++;
        $display("FAIL stretch_repulse i=%0d led=%b want0=%b model=%b", i, led, (i >= 1 && i <= 25), m_led);
      end
    end
  endtask

  task automatic test_blink();
    wr_reg(4'h2, 8'h88);
    wr_reg(4'hF, 8'h01);
    for (int i = 0; i < 80; i++) begin
      tick();
      n_vec++;
      if (led !== m_led) begin
        n_err++; $display("FAIL blink_rate1 i=%0d led=%b want=%b", i, led, m_led);
      end
    end
    wr_reg(4'hF, 8'h03);
    rd_reg(4'hF);
    n_vec++;
    if (u_if.D_o !== 8'h03) begin
      n_err++; $display("FAIL global_read got=%h want=03", u_if.D_o);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      n_vec++;
      if (led !== m_led) begin
        n_err++; $display("FAIL blink_rate3 i=%0d led=%b want=%b", i, led, m_led);
      end
    end
  endtask

  task automatic test_bus_edges();
    logic [3:0] a;
    wr_reg(4'hE, 8'hFF);
    wr_reg(4'h7, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      a = (i < 4) ? 4'(i) : 4'hF;
      rd_reg(a);
      n_vec++;
      if (u_if.D_o !== m_dout) begin
        n_err++; $display("FAIL ignored_write a=%h got=%h want=%h", a, u_if.D_o, m_dout);
      end
    end
    rd_reg(4'h7);
    n_vec++;
    if (u_if.D_o !== 8'h00) begin
      n_err++; $display("FAIL read_unmapped7 got=%h want=00", u_if.D_o);
    end
    rd_reg(4'h2);
    rd_reg(4'h9);
    n_vec++;
    if (u_if.D_o !== 8'h00) begin
      n_err++; $display("FAIL read_unmapped9 got=%h want=00", u_if.D_o);
    end
    wr_reg(4'h0, 8'h5F);
    rd_reg(4'h0);
    n_vec++;
    if (u_if.D_o !== 8'h4F) begin
      n_err++; $display("FAIL duty_trunc got=%h want=4F", u_if.D_o);
    end
    u_if.wr_i = 1'b1; u_if.rd_i = 1'b1; u_if.A_i = 4'h1; u_if.D_i = 8'h41;
    tick();
    u_if.wr_i = 1'b0; u_if.rd_i = 1'b0;
    n_vec++;
    if (u_if.D_o !== 8'h43) begin
      n_err++; $display("FAIL rd_wr_same got=%h want=43", u_if.D_o);
    end
    rd_reg(4'h1);
    n_vec++;
    if (u_if.D_o !== 8'h41) begin
      n_err++; $display("FAIL rd_after_wr got=%h want=41", u_if.D_o);
    end
  endtask

  task automatic test_level_reset();
    lvl[3] = 1'b1;
    wr_reg(4'h3, 8'hC0);
    for (int i = 0; i < 20; i++) begin
      tick();
      n_vec++;
      if (led[3] !== 1'b0) begin
        n_err++; $display("FAIL level_duty0 i=%0d led3=%b want=0", i, led[3]);
      end
    end
    wr_reg(4'h3, 8'hC8);
    for (int i = 0; i < 16; i++) begin
      tick();
      n_vec++;
      if (led !== m_led) begin
        n_err++; $display("FAIL level_pwm i=%0d led=%b want=%b", i, led, m_led);
      end
    end
    act[3] = 1'b1;
    tick();
    act[3] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (led[3] !== 1'b1) begin
        n_err++; $display("FAIL stretch_full i=%0d led3=%b want=1", i, led[3]);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if (led !== 4'b0000) begin
      n_err++; $display("FAIL reset_mid_stretch led=%b want=0000", led);
    end
    lvl = '0;
    rd_reg(4'h3);
    n_vec++;
    if (u_if.D_o !== 8'hC8) begin
      n_err++; $display("FAIL reset_ctrl3 got=%h want=C8", u_if.D_o);
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NL; c++) act[c] = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 15) == 0) lvl = 4'($urandom);
      r = $urandom_range(0, 9);
      u_if.wr_i = (r < 3);
      u_if.rd_i = (r >= 2 && r < 6);
      u_if.A_i  = 4'($urandom);
      if ($urandom_range(0, 1) == 0) u_if.A_i = 4'($urandom_range(0, 3));
      u_if.D_i  = 8'($urandom);
      rst = ($urandom_range(0, 249) == 0);
      tick();
      n_vec++;
      if (led !== m_led || u_if.D_o !== m_dout) begin
        n_err++;
        $display("FAIL random i=%0d led=%b dout=%h want led=%b dout=%h", i, led, u_if.D_o, m_led, m_dout);
      end
    end
    rst = 1'b0; act = '0; lvl = '0; u_if.wr_i = 1'b0; u_if.rd_i = 1'b0;
  endtask

  initial begin
    u_if.wr_i = 1'b0; u_if.rd_i = 1'b0; u_if.A_i = 4'h0; u_if.D_i = 8'h00;
    test_reset();
    test_pwm_on();
    test_activity();
    test_blink();
    test_bus_edges();
    test_level_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
